// File: rtl/pc_sequencer_pkg.sv
// Shared defaults and next-PC source encoding for the fetch-stage PC sequencer.
package pc_pkg;

    localparam int unsigned      ADDR_W_DFLT    = 16;
    localparam logic [15:0]      RESET_VEC_DFLT = 16'h0000;
    localparam logic [15:0]      EXC_VEC_DFLT   = 16'h0004;
    localparam int unsigned      ALIGN_BITS     = 1;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_RET,
        SEL_EXC
    } next_sel_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/handshake bundle between the fetch control and the PC sequencer.
interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DFLT
) ();

    logic              stall;
    logic              fetch_ready;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_offset;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              call;
    logic              ret;
    logic              exc;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_underflow;
    logic              align_fault;

    modport master (
        output stall, fetch_ready, branch_taken, branch_offset, jump, jump_target,
               call, ret, exc,
        input  pc, pc_valid, ras_empty, ras_full, ras_underflow, align_fault
    );

    modport slave (
        input  stall, fetch_ready, branch_taken, branch_offset, jump, jump_target,
               call, ret, exc,
        output pc, pc_valid, ras_empty, ras_full, ras_underflow, align_fault
    );

endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: push on full overwrites the oldest entry,
// push+pop replaces the top, pop on empty raises a one-cycle underflow pulse.
module pc_ras #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d, top_idx, wr_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en, uf_d, uf_q;

    assign top_idx   = wp_q - PTR_W'(1);
    assign top       = mem_q[top_idx];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign underflow = uf_q;

    always_comb begin
        wp_d   = wp_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = wp_q;
        uf_d   = 1'b0;
        if (clear) begin
            wp_d  = '0;
            cnt_d = '0;
        end else if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            // Pointer wraps, so a push on full lands on the oldest slot.
            wr_en = 1'b1;
            wp_d  = wp_q + PTR_W'(1);
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            uf_d = pop;
        end else if (pop) begin
            if (empty) begin
                uf_d = 1'b1;
            end else begin
                wp_d  = top_idx;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            cnt_q <= '0;
            uf_q  <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with branch/jump/return/exception redirect and a RAS.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets to the exception vector.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned          ADDR_W    = ADDR_W_DFLT,
    parameter int unsigned          INC       = 1,
    parameter logic [ADDR_W-1:0]    RESET_VEC = ADDR_W'(RESET_VEC_DFLT),
    parameter logic [ADDR_W-1:0]    EXC_VEC   = ADDR_W'(EXC_VEC_DFLT),
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, br_target, ras_top;
    logic              pc_valid_q, adv;
    logic              ras_push, ras_pop, ras_clear, ras_empty;
    logic              fault_d;
    next_sel_t         sel;

    always_comb begin
        adv       = pc_valid_q & bus.fetch_ready & ~bus.stall;
        pc_inc    = pc_q + ADDR_W'(INC);
        br_target = pc_inc + bus.branch_offset;
        sel       = SEL_SEQ;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        fault_d   = 1'b0;

        if (bus.exc) begin
            sel = SEL_EXC;
        end else if (adv) begin
            ras_pop  = bus.ret;
            ras_push = bus.call & (bus.jump | bus.ret);
            if (bus.ret) begin
                // An empty stack falls through to sequential; the RAS flags underflow.
                sel = ras_empty ? SEL_SEQ : SEL_RET;
            end else if (bus.jump) begin
                sel = SEL_JMP;
            end else if (bus.branch_taken) begin
                sel = SEL_BR;
            end
        end

        unique case (sel)
            SEL_EXC: pc_d = EXC_VEC;
            SEL_RET: pc_d = ras_top;
            SEL_JMP: pc_d = bus.jump_target;
            SEL_BR:  pc_d = br_target;
            default: pc_d = adv ? pc_inc : pc_q;
        endcase

`ifdef PC_ALIGN_CHECK_EN
        if ((sel inside {SEL_JMP, SEL_RET, SEL_BR}) && (pc_d[ALIGN_BITS-1:0] != '0)) begin
            fault_d  = 1'b1;
            pc_d     = EXC_VEC;
            ras_push = 1'b0;
            ras_pop  = 1'b0;
        end
`endif

        ras_clear = bus.exc | fault_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= 1'b1;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign bus.align_fault = fault_q;
`else
    assign bus.align_fault = 1'b0;
`endif

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .clear     (ras_clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (bus.ras_full),
        .underflow (bus.ras_underflow)
    );

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = pc_valid_q;
    assign bus.ras_empty = ras_empty;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter block for the 16-bit MIPS fetch stage; successor to the plain PC register.
- Holds the current fetch address and computes the next one from increment, branch, jump, return and exception sources.
- Handshakes with instruction memory and applies stalls.
- Contains a small circular return-address stack (RAS) for call/return.

Parameters:
- ADDR_W, 16, PC and address width.
- INC, 1, increment per instruction (word-addressed).
- RESET_VEC, 0, PC value loaded on reset.
- EXC_VEC, 16'h0004, exception handler address.
- RAS_DEPTH, 4, return-stack entries (power of two, >=2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  pipeline hold.
- fetch_ready  in  1  instruction memory accepts pc this cycle.
- branch_taken  in  1  relative branch.
- branch_offset  in  ADDR_W  two's-complement offset.
- jump  in  1  absolute jump.
- jump_target  in  ADDR_W  jump address.
- call  in  1  with jump, push return address.
- ret  in  1  return; target popped from RAS.
- exc  in  1  exception request.
- pc  out  ADDR_W  current fetch address.
- pc_valid  out  1  pc presented to instruction memory.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_underflow  out  1  one-cycle pulse: ret with empty RAS.
- align_fault  out  1  one-cycle pulse (see Optional Feature).

Behaviour:
Reset (rst high at a clock edge):
- pc=RESET_VEC, pc_valid=0, RAS count=0, ras_empty=1, ras_full=0, pulses 0.
- pc_valid rises in the first cycle after rst deasserts.
- rst overrides every other input and clears any in-flight redirect.

Advance rule:
- adv = pc_valid & fetch_ready & ~stall.
- When adv=0 and exc=0: pc and RAS hold; all redirect inputs are ignored.

Next-PC priority, registered, one-cycle latency:
- exc: EXC_VEC. Applies regardless of adv; clears RAS count to 0.
- ret (adv): RAS top, popped. If RAS empty: pc+INC, ras_underflow=1.
- jump (adv): jump_target. With call, also push pc+INC.
- branch_taken (adv): pc+INC+branch_offset.
- otherwise (adv): pc+INC.

Arithmetic: all modulo 2^ADDR_W; wrap from max to 0 is silent.

RAS push on full:
- Overwrites the oldest entry (circular).
- Count stays RAS_DEPTH; ras_full stays 1.

Simultaneous events:
- ret & call & jump: target is the RAS top; the top entry is replaced by pc+INC; count unchanged.
- ret & call with RAS empty: target is pc+INC; pc+INC is pushed; count=1; ras_underflow=1.
- Inputs asserted together with exc are discarded.

Flag timing: ras_empty and ras_full are registered and reflect the count after the edge.

Optional Feature:
Macro PC_ALIGN_CHECK_EN (with localparam ALIGN_BITS=1).

Defined:
- A jump_target, RAS target or branch target with nonzero low ALIGN_BITS is not taken.
- pc <= EXC_VEC, align_fault pulses one cycle, RAS is cleared, same as exc.

Undefined:
- No alignment check is performed.
- align_fault is tied to 0; the port is always present.

Decomposition:
- Package pc_pkg: ADDR_W default, RESET_VEC, EXC_VEC, and an enum next_sel_t {SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET, SEL_EXC}.
- Sub-module pc_ras: circular stack with push, pop, push+pop replace, clear, full/empty/underflow.
- Top level contains the selection logic and the PC register.

Test Plan:
- Reset, then adv every cycle, INC=1: pc 0,1,2,3; pc_valid=0 during rst, 1 after.
- pc=16'h0010, branch_taken, offset=16'hFFFC: next pc=16'h000D; with stall=1 held, pc stays 16'h0010.
- jump+call to 16'h0100 from pc=16'h0020, then ret at 16'h0105: pc=16'h0100, later 16'h0021; ras_empty returns to 1.
- Five nested calls (RAS_DEPTH=4) then five rets: first four return the newest four addresses; fifth gives pc+INC with ras_underflow=1.
- exc while fetch_ready=0 and ret asserted: pc=16'h0004, RAS count=0, ret ignored.
- With PC_ALIGN_CHECK_EN, jump to 16'h0101: pc=EXC_VEC, align_fault=1 for one cycle. Without the macro: pc=16'h0101.
